// File: rtl/pkt_send_pkg.sv
// Shared types and constants for the packet byte sender and its sync generator.
package pkt_send_pkg;

  typedef enum logic [2:0] {
    SYNC_IDLE,
    SYNC_S0,
    SYNC_S1,
    SYNC_S2,
    SYNC_S3
  } sync_state_e;

  localparam logic [7:0]  SYNC_FILL_BYTE = 8'hFF;
  localparam logic [7:0]  SYNC_LAST_BYTE = 8'h7F;
  localparam int unsigned DROP_CNT_W     = 16;

  // Saturating increment for the drop counter.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pkt_sync_gen.sv
// Sync interval timer and FF,FF,FF,7F sync sequencer.
// Instantiated by pkt_byte_sender only when PKT_SYNC_INSERT_EN is defined.
module pkt_sync_gen
  import pkt_send_pkg::*;
#(
  parameter int unsigned SYNC_IVL_LOG2 = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync_ok_i,
  input  logic       req_i,
  input  logic       boundary_i,
  output logic       take_o_c,
  output logic [7:0] byte_o_c
);

  sync_state_e              state_q, state_d;
  logic [SYNC_IVL_LOG2-1:0] timer_q, timer_d;
  logic                     start_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYNC_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // A sequence only starts on a packet boundary so it never splits a packet.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    take_o_c = 1'b0;
    byte_o_c = SYNC_FILL_BYTE;
    start_c  = boundary_i && sync_ok_i && (timer_q == '0);
    if (timer_q != '0) timer_d = timer_q - SYNC_IVL_LOG2'(1);
    case (state_q)
      SYNC_IDLE: begin
        take_o_c = start_c;
        if (req_i && start_c) state_d = SYNC_S0;
      end
      SYNC_S0: begin
        take_o_c = 1'b1;
        if (req_i) state_d = SYNC_S1;
      end
      SYNC_S1: begin
        take_o_c = 1'b1;
        if (req_i) state_d = SYNC_S2;
      end
      SYNC_S2: begin
        take_o_c = 1'b1;
        byte_o_c = SYNC_LAST_BYTE;
        if (req_i) begin
          state_d = SYNC_S3;
          timer_d = '1;
        end
      end
      SYNC_S3: state_d = SYNC_IDLE;
      default: state_d = SYNC_IDLE;
    endcase
  end

endmodule

// File: rtl/pkt_byte_sender.sv
// Packet word buffer with commit/discard semantics, serialised to bytes on request.
// Optional sync byte insertion is enabled by defining PKT_SYNC_INSERT_EN.
module pkt_byte_sender
  import pkt_send_pkg::*;
#(
  parameter int unsigned WORD_BYTES       = 2,
  parameter int unsigned DEPTH_LOG2       = 12,
  parameter int unsigned PKT_WORDS_LOG2   = 3,
  parameter int unsigned SYNC_IVL_LOG2    = 17,
  parameter int unsigned OVF_STRETCH_LOG2 = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sync_ok,
  input  logic                    wd_avail,
  input  logic                    pkt_reset,
  input  logic [8*WORD_BYTES-1:0] pkt_wd,
  input  logic                    data_next,
  output logic [7:0]              data_val,
  output logic                    data_ready,
  output logic                    data_overf,
  output logic [15:0]             drop_count
);

  localparam int unsigned WORD_W = 8 * WORD_BYTES;
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned BIDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_BIDX = BIDX_W'(WORD_BYTES - 1);

  logic [WORD_W-1:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]       wp_q, wp_d, cwp_q, cwp_d, rp_q, rp_d, wp_inc_c;
  logic                        ovf_q, ovf_d, ready_q, ready_d, overf_q;
  logic [BIDX_W-1:0]           bidx_q, bidx_d;
  logic [15:0]                 drop_q, drop_d;
  logic [OVF_STRETCH_LOG2-1:0] stretch_q, stretch_d;
  logic [7:0]                  val_q, val_d, rd_byte_c, sync_byte_c;
  logic                        wr_en_c, accept_c, boundary_c, sync_take_c;

`ifdef PKT_SYNC_INSERT_EN
  pkt_sync_gen #(.SYNC_IVL_LOG2(SYNC_IVL_LOG2)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .sync_ok_i  (sync_ok),
    .req_i      (accept_c),
    .boundary_i (boundary_c),
    .take_o_c   (sync_take_c),
    .byte_o_c   (sync_byte_c)
  );
`else
  logic unused_sync_c;
  assign sync_take_c   = 1'b0;
  assign sync_byte_c   = SYNC_FILL_BYTE;
  assign unused_sync_c = sync_ok ^ boundary_c ^ (SYNC_IVL_LOG2 != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q      <= '0;
      cwp_q     <= '0;
      rp_q      <= '0;
      ovf_q     <= 1'b0;
      bidx_q    <= '0;
      drop_q    <= '0;
      stretch_q <= '0;
      overf_q   <= 1'b0;
      val_q     <= 8'h00;
      ready_q   <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      cwp_q     <= cwp_d;
      rp_q      <= rp_d;
      ovf_q     <= ovf_d;
      bidx_q    <= bidx_d;
      drop_q    <= drop_d;
      stretch_q <= stretch_d;
      overf_q   <= (stretch_d != '0);
      val_q     <= val_d;
      ready_q   <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wp_q] <= pkt_wd;
  end

  // Write side: pkt_reset rewinds to the last committed packet and wins over data.
  always_comb begin
    wp_d     = wp_q;
    cwp_d    = cwp_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    wp_inc_c = wp_q + DEPTH_LOG2'(1);
    wr_en_c  = 1'b0;
    if (pkt_reset) begin
      wp_d  = cwp_q;
      ovf_d = 1'b0;
    end else if (wd_avail && !ovf_q) begin
      if (wp_inc_c == rp_q) begin
        ovf_d  = 1'b1;
        drop_d = sat_inc(drop_q);
      end else begin
        wr_en_c = 1'b1;
        wp_d    = wp_inc_c;
        if (wp_inc_c[PKT_WORDS_LOG2-1:0] == '0) cwp_d = wp_inc_c;
      end
    end
    if (ovf_q)                stretch_d = '1;
    else if (stretch_q != '0) stretch_d = stretch_q - OVF_STRETCH_LOG2'(1);
    else                      stretch_d = stretch_q;
  end

  // Read side: one byte per accepted request, sync bytes take precedence.
  always_comb begin
    rp_d       = rp_q;
    bidx_d     = bidx_q;
    val_d      = val_q;
    ready_d    = 1'b0;
    accept_c   = data_next && !ready_q;
    boundary_c = (rp_q[PKT_WORDS_LOG2-1:0] == '0) && (bidx_q == '0);
    rd_byte_c  = 8'(mem_q[rp_q] >> {bidx_q, 3'b000});
    if (accept_c) begin
      if (sync_take_c) begin
        ready_d = 1'b1;
        val_d   = sync_byte_c;
      end else if (rp_q != cwp_q) begin
        ready_d = 1'b1;
        val_d   = rd_byte_c;
        if (bidx_q == LAST_BIDX) begin
          bidx_d = '0;
          rp_d   = rp_q + DEPTH_LOG2'(1);
        end else begin
          bidx_d = bidx_q + BIDX_W'(1);
        end
      end
    end
  end

  assign data_val   = val_q;
  assign data_ready = ready_q;
  assign data_overf = overf_q;
  assign drop_count = drop_q;

endmodule

// File: doc/pkt_byte_sender.md
PKT_BYTE_SENDER -- requirements
Module: pkt_byte_sender

Interface
REQ-001 Parameter WORD_BYTES, default 2: bytes per packet word; legal values 1, 2, 4.
REQ-002 Parameter DEPTH_LOG2, default 12: log2 of the buffer depth in words.
REQ-003 Parameter PKT_WORDS_LOG2, default 3: log2 of the words per packet; SHALL be less than DEPTH_LOG2.
REQ-004 Parameter SYNC_IVL_LOG2, default 17: width of the sync interval timer.
REQ-005 Parameter OVF_STRETCH_LOG2, default 26: width of the overflow indicator stretch counter.
REQ-006 Port clk, input, 1 bit: single system clock; reset is synchronous and active-high.
REQ-007 Port rst, input, 1 bit: synchronous active-high reset.
REQ-008 Port sync_ok, input, 1 bit: upstream decoder is in sync.
REQ-009 Port wd_avail, input, 1 bit: pkt_wd is valid this cycle.
REQ-010 Port pkt_reset, input, 1 bit: discard the partial packet and clear the overflow state.
REQ-011 Port pkt_wd, input, 8*WORD_BYTES bits: packet word.
REQ-012 Port data_next, input, 1 bit: consumer requests a byte.
REQ-013 Port data_val, output, 8 bits: byte presented to the consumer.
REQ-014 Port data_ready, output, 1 bit: one-cycle pulse; data_val is valid.
REQ-015 Port data_overf, output, 1 bit: stretched overflow indication.
REQ-016 Port drop_count, output, 16 bits: number of dropped packets, saturating.

Function
REQ-017 The buffer SHALL use three pointers, each DEPTH_LOG2 bits wide and wrapping modulo 2^DEPTH_LOG2:
- wp: write pointer.
- cwp: committed write pointer.
- rp: read pointer.
REQ-018 Write: when wd_avail is high, pkt_reset is low and ovf is low, pkt_wd SHALL be written at wp and wp SHALL be incremented.
REQ-019 Commit: when a write makes the low PKT_WORDS_LOG2 bits of wp+1 equal to zero, cwp SHALL become wp+1 in the same cycle.
REQ-020 Full: when wd_avail is high and wp+1 equals rp, the word SHALL be discarded, ovf SHALL be set, and drop_count SHALL be incremented once per overflow event (saturating at 16'hFFFF).
- Usable capacity is 2^DEPTH_LOG2 - 1 words.
REQ-021 While ovf is set, all words SHALL be discarded until pkt_reset is seen.
REQ-022 pkt_reset SHALL set wp to cwp and clear ovf.
- pkt_reset has priority over a simultaneous wd_avail; that word is dropped.
REQ-023 Read handshake: a request is accepted on a cycle where data_next is high and data_ready is low.
- data_ready SHALL pulse high on the following cycle with data_val stable.
- data_ready SHALL never be high on two consecutive cycles.
REQ-024 A data byte SHALL be served only if rp differs from cwp; uncommitted words are never read.
REQ-025 Byte order SHALL be little-endian within a word: byte index 0 first.
- rp SHALL increment after byte WORD_BYTES-1 of the word is served.
REQ-026 When no byte is eligible, the request SHALL produce no data_ready; the consumer re-requests.
REQ-027 Reads and writes in the same cycle SHALL both take effect.
REQ-028 ovf SHALL reload the stretch counter to all-ones; otherwise the counter decrements to zero.
- data_overf SHALL equal (stretch counter != 0).

Reset
REQ-029 When rst is high, the following SHALL be cleared: wp, cwp, rp, ovf, byte index, drop_count, stretch counter, sync timer and sync FSM.
- data_ready SHALL be 0 and data_val SHALL be 8'h00.
REQ-030 rst asserted mid-packet or mid-sync SHALL abandon all buffered data; the first output after reset follows REQ-031 rules.

Configuration
REQ-031 With PKT_SYNC_INSERT_EN defined, sync insertion SHALL be enabled:
- The sync timer decrements to zero.
- A request accepted at a packet boundary (rp low PKT_WORDS_LOG2 bits equal to zero, byte index 0), with the timer at zero and sync_ok high, SHALL start the sync FSM (IDLE->S0->S1->S2->S3->IDLE).
- The FSM emits FF, FF, FF, 7F, one byte per accepted request, and SHALL NOT be interleaved with data.
- The timer SHALL reload to all-ones on the 7F byte.
- Deassertion of sync_ok mid-sequence SHALL NOT abort the sequence.
REQ-032 Without PKT_SYNC_INSERT_EN, the FSM and timer SHALL be absent and only data bytes are served.

Structure
REQ-033 Package pkt_send_pkg SHALL hold the sync FSM state enum and the constants SYNC_FILL_BYTE=8'hFF and SYNC_LAST_BYTE=8'h7F.
REQ-034 Sub-module pkt_sync_gen SHALL contain the sync timer and FSM; it is instantiated only under PKT_SYNC_INSERT_EN.

Verification
REQ-035 Directed scenario: WORD_BYTES=2; write 8 words 16'h0100..16'h0807; request 16 bytes -> 00,01,01,02,...,07,08 in order, each with a single-cycle data_ready.
REQ-036 Directed scenario: write 5 words then pulse pkt_reset; request bytes -> no data_ready; cwp and wp remain 0.
REQ-037 Directed scenario: DEPTH_LOG2=4; write 20 words with no reads -> ovf after 15 words, drop_count=1, data_overf high; after pkt_reset only the first 8 committed words are readable.
REQ-038 Directed scenario: PKT_SYNC_INSERT_EN defined, sync_ok=1, timer expired, empty buffer; request 4 bytes -> FF, FF, FF, 7F; the fifth request yields no byte until the timer expires again.
REQ-039 Directed scenario: assert rst during S2 of a sync sequence -> all outputs at reset values next cycle; after reset the next 4 requests yield FF, FF, FF, 7F.
